cv32e40x_div_ctrl: RTL and testbench
====================================

Name: cv32e40x_div_ctrl

Overview:
- Issue/retire controller directly upstream and downstream of the serial divider.
- Captures DIV/DIVU/REM/REMU requests from EX, holds the operands stable for the divider, and drives the divider's valid/kill and ready handshake.
- Registers the divider result toward writeback.
- Optionally resolves RISC-V special cases (divide-by-zero, signed overflow) without starting the divider.

Parameters:
- RESET_RESULT, 32'h0, value of the result register after reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- valid_i  input  1  EX request valid
- ready_o  output  1  controller can accept a request
- kill_i  input  1  abort current operation (flush)
- operator_i  input  2  div_opcode_e: DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU
- data_ind_timing_i  input  1  data-independent timing mode
- op_a_i  input  32  dividend
- op_b_i  input  32  divisor
- div_en_o  output  1  divider enable (ALU CLZ/shifter sharing)
- div_valid_o  output  1  divider valid_i; low kills the divider
- div_ready_i  input  1  divider ready_o
- div_valid_i  input  1  divider valid_o
- div_ready_o  output  1  divider ready_i
- div_operator_o  output  2  registered operator
- div_op_a_o  output  32  registered op_a
- div_op_b_o  output  32  registered op_b
- div_data_ind_timing_o  output  1  registered data_ind_timing
- div_result_i  input  32  divider result_o
- valid_o  output  1  result valid toward writeback
- ready_i  input  1  writeback ready
- result_o  output  32  registered result

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low. All flops update only on posedge clk; rst_n low at an edge clears everything.
- Reset values: state=IDLE, operand/operator regs=0, result_o=RESET_RESULT, valid_o=0, div_valid_o=0, div_en_o=0, div_ready_o=0. While rst_n is low, ready_o=0.
- States: IDLE, BUSY, DONE.
- ready_o = (state==IDLE) || (state==DONE && ready_i). Accepting a new request in the same cycle a result drains is allowed (back-to-back).
- Accept: valid_i && ready_o && !kill_i captures operator_i, op_a_i, op_b_i, data_ind_timing_i.
  - If the request is a fast-path case, the special result is written to result_o and the next state is DONE, so valid_o is high 1 cycle after accept.
  - Otherwise the next state is BUSY.
- BUSY:
  - div_en_o=1 and div_valid_o=1. Operand outputs are held constant.
  - div_ready_o=1; the divider asserts div_valid_i only in its finish state.
  - On div_valid_i: result_o<=div_result_i and the next state is DONE. The divider returns to its own idle state the same edge.
- DONE:
  - valid_o=1 and result_o is stable.
  - ready_i drains the result: next state IDLE, or back-to-back accept.
- Total latency on the divider path = divider latency + 1 register cycle.
- kill_i in any state:
  - Next state IDLE; valid_o is 0 the next cycle.
  - div_valid_o is forced 0 combinationally that cycle, which kills the divider.
  - No accept that cycle, even if valid_i is high.
  - result_o retains its value.
- div_valid_i outside BUSY is ignored.
- If valid_i drops in BUSY without kill_i, the operation continues; kill_i is the only abort.
- Operand regs change only on accept.

Optional Feature:
- Macro DIV_FASTPATH_EN.
- With the macro defined, when data_ind_timing_i==0 at accept, the following resolve at accept:
  - op_b==0: DIV/DIVU result 32'hFFFFFFFF; REM/REMU result op_a.
  - DIV with op_a==32'h80000000 and op_b==32'hFFFFFFFF: result 32'h80000000.
  - REM with the same operands: result 32'h0.
  - The divider is never enabled for these cases.
- With data_ind_timing_i==1, every request goes to the divider.
- Without the macro, all requests take the divider path and no special-case logic exists.

Test Plan:
- DIVU 100/7, ready_i=1: div_valid_o held until div_valid_i; the next cycle valid_o=1, result_o=14; ready_o=1 the same cycle (back-to-back).
- REM, op_a=-7 (32'hFFFFFFF9), op_b=2: result_o=32'hFFFFFFFF via the divider; ready_i held 0 for 3 cycles keeps valid_o=1 and result_o stable, with no new accept.
- DIV_FASTPATH_EN defined, DIV x/0 with data_ind_timing_i=0: valid_o=1 one cycle after accept, result_o=32'hFFFFFFFF, div_en_o never asserted. With data_ind_timing_i=1, the request instead goes through the divider and gives the same result.
- DIV_FASTPATH_EN defined, DIV 32'h80000000/-1: result 32'h80000000 in 1 cycle. REM with the same operands: result 0.
- kill_i asserted mid-BUSY together with valid_i=1: div_valid_o=0 that cycle, state IDLE next, valid_o stays 0, no accept. A following DIVU 9/3 then gives 3.
- rst_n low for one edge during BUSY: all outputs return to reset values; a subsequent request completes correctly.

Source files
------------

// File: rtl/cv32e40x_div_ctrl.sv
// cv32e40x_div_ctrl: issue/retire controller wrapped around the serial divider.
// Accepts DIV/DIVU/REM/REMU requests from EX and holds their operands for the
// divider. It drives the divider valid/kill and ready handshake, and registers
// the divider result toward writeback.
// Optional feature: define DIV_FASTPATH_EN to resolve divide-by-zero and signed
// overflow at accept time, without starting the divider. This only applies when
// data-independent timing is off.
module cv32e40x_div_ctrl #(
  parameter logic [31:0] RESET_RESULT = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        kill_i,
  input  logic [1:0]  operator_i,
  input  logic        data_ind_timing_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        div_en_o,
  output logic        div_valid_o,
  input  logic        div_ready_i,
  input  logic        div_valid_i,
  output logic        div_ready_o,
  output logic [1:0]  div_operator_o,
  output logic [31:0] div_op_a_o,
  output logic [31:0] div_op_b_o,
  output logic        div_data_ind_timing_o,
  input  logic [31:0] div_result_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  localparam int DATA_W = 32;

  localparam logic [1:0] DIV_DIV  = 2'd0;
  localparam logic [1:0] DIV_DIVU = 2'd1;
  localparam logic [1:0] DIV_REM  = 2'd2;
  localparam logic [1:0] DIV_REMU = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state;
  logic              div_valid_q;
  logic              accept;
  logic              fast_hit;
  logic [DATA_W-1:0] fast_res;

  // A drained result frees the controller in the same cycle, which allows back-to-back issue
  assign ready_o     = rst_n && ((state == IDLE) || ((state == DONE) && ready_i));
  assign accept      = valid_i && ready_o && !kill_i;
  // kill_i must reach the divider in the cycle it is raised, so it bypasses the register
  assign div_valid_o = div_valid_q && !kill_i;

`ifdef DIV_FASTPATH_EN
  localparam logic signed [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] NEG_ONE = {DATA_W{1'b1}};

  // Returns {hit, result} for the RISC-V special cases that need no division
  function automatic logic [DATA_W:0] fast_path(input logic [1:0]               op,
                                                input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    if (b == '0) begin
      if ((op == DIV_DIV) || (op == DIV_DIVU)) r = {1'b1, {DATA_W{1'b1}}};
      else                                     r = {1'b1, a};
    end else if ((a == INT_MIN) && (b == NEG_ONE)) begin
      if (op == DIV_DIV)      r = {1'b1, INT_MIN};
      else if (op == DIV_REM) r = {1'b1, {DATA_W{1'b0}}};
    end
    return r;
  endfunction

  // Fast-path detection is suppressed in data-independent timing mode
  always_comb begin
    {fast_hit, fast_res} = '0;
    if (!data_ind_timing_i) {fast_hit, fast_res} = fast_path(operator_i, op_a_i, op_b_i);
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // Control FSM with registered handshake outputs, operand capture and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      div_operator_o        <= DIV_DIV;
      div_op_a_o            <= '0;
      div_op_b_o            <= '0;
      div_data_ind_timing_o <= 1'b0;
      result_o              <= RESET_RESULT;
      valid_o               <= 1'b0;
      div_valid_q           <= 1'b0;
      div_en_o              <= 1'b0;
      div_ready_o           <= 1'b0;
    end else begin
      if (accept) begin
        div_operator_o        <= operator_i;
        div_op_a_o            <= op_a_i;
        div_op_b_o            <= op_b_i;
        div_data_ind_timing_o <= data_ind_timing_i;
      end
      if (kill_i) begin
        state       <= IDLE;
        valid_o     <= 1'b0;
        div_valid_q <= 1'b0;
        div_en_o    <= 1'b0;
        div_ready_o <= 1'b0;
      end else if (accept) begin
        if (fast_hit) begin
          result_o    <= fast_res;
          state       <= DONE;
          valid_o     <= 1'b1;
          div_valid_q <= 1'b0;
          div_en_o    <= 1'b0;
          div_ready_o <= 1'b0;
        end else begin
          state       <= BUSY;
          valid_o     <= 1'b0;
          div_valid_q <= 1'b1;
          div_en_o    <= 1'b1;
          div_ready_o <= 1'b1;
        end
      end else begin
        case (state)
          BUSY: begin
            if (div_valid_i) begin
              result_o    <= div_result_i;
              state       <= DONE;
              valid_o     <= 1'b1;
              div_valid_q <= 1'b0;
              div_en_o    <= 1'b0;
              div_ready_o <= 1'b0;
            end
          end
          DONE: begin
            if (ready_i) begin
              state   <= IDLE;
              valid_o <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_div_ctrl.sv
// Testbench for cv32e40x_div_ctrl: a behavioural serial divider with random
// latency, plus a RISC-V arithmetic reference for every request issued.
module tb_cv32e40x_div_ctrl;

  localparam logic [31:0] RST_RES = 32'hDEAD_BEEF;
  localparam logic [1:0]  DIV  = 2'd0;
  localparam logic [1:0]  DIVU = 2'd1;
  localparam logic [1:0]  REM  = 2'd2;
  localparam logic [1:0]  REMU = 2'd3;

  logic        clk, rst_n, valid_i, ready_o, kill_i, data_ind_timing_i;
  logic [1:0]  operator_i, div_operator_o;
  logic [31:0] op_a_i, op_b_i, div_op_a_o, div_op_b_o, div_result_i, result_o;
  logic        div_en_o, div_valid_o, div_ready_i, div_valid_i, div_ready_o;
  logic        div_data_ind_timing_o, valid_o, ready_i;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_min = 2;
  int lat_max = 5;
  logic [31:0] last_res;

  cv32e40x_div_ctrl #(.RESET_RESULT(RST_RES)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .kill_i(kill_i),
    .operator_i(operator_i), .data_ind_timing_i(data_ind_timing_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .div_en_o(div_en_o), .div_valid_o(div_valid_o),
    .div_ready_i(div_ready_i), .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_operator_o(div_operator_o), .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
    .div_data_ind_timing_o(div_data_ind_timing_o), .div_result_i(div_result_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension division semantics
  function automatic logic [31:0] rv_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      DIV:     return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic dit);
`ifdef DIV_FASTPATH_EN
    if (dit) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural serial divider: 0 idle, 1 running, 2 finished
  int          dv_state;
  int          dv_cnt;
  logic [31:0] dv_res;
  assign div_ready_i  = (dv_state == 0);
  assign div_valid_i  = (dv_state == 2);
  assign div_result_i = dv_res;

  always @(posedge clk) begin
    if (!rst_n) begin
      dv_state <= 0;
      dv_cnt   <= 0;
      dv_res   <= 32'h0;
    end else begin
      case (dv_state)
        0: if (div_valid_o) begin
             dv_state <= 1;
             dv_cnt   <= $urandom_range(lat_max, lat_min);
             dv_res   <= rv_div(div_operator_o, div_op_a_o, div_op_b_o);
           end
        1: if (!div_valid_o) dv_state <= 0;
           else if (dv_cnt <= 1) dv_state <= 2;
           else dv_cnt <= dv_cnt - 1;
        default: if (!div_valid_o || div_ready_o) dv_state <= 0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it until the result appears on valid_o
  task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic dit, input int stall, input bit drain);
    logic [31:0] exp;
    bit          fast, saw_en;
    int          cycles, fin;
    exp  = rv_div(op, a, b);
    fast = is_fast(op, a, b, dit);
    for (int k = 0; k < 50 && !ready_o; k++) @(negedge clk);
    check_eq("issue_rdy", ready_o, 1);
    valid_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b; data_ind_timing_i = dit;
    cycles = 0; fin = -1; saw_en = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        valid_i = 1'b0;
        op_a_i  = $urandom;
        op_b_i  = $urandom;
        ready_i = (stall == 0);
      end
      if (div_en_o) saw_en = 1;
      if (div_valid_i && fin < 0) begin
        fin = cycles;
        check_eq("hold_a", div_op_a_o, a);
        check_eq("hold_b", div_op_b_o, b);
        check_eq("hold_op", {30'b0, div_operator_o}, {30'b0, op});
        check_eq("hold_dit", {31'b0, div_data_ind_timing_o}, {31'b0, dit});
        check_eq("busy_dvld", {31'b0, div_valid_o}, 32'd1);
        check_eq("busy_drdy", {31'b0, div_ready_o}, 32'd1);
      end
    end while (!valid_o && cycles < 300);
    check_eq("res_vld", valid_o, 1);
    check_eq("result", result_o, exp);
    if (fast) begin
      check_eq("fast_lat", cycles, 1);
      check_eq("fast_noen", {31'b0, saw_en}, 0);
    end else begin
      check_eq("div_lat", cycles, fin + 1);
      check_eq("div_used", {31'b0, saw_en}, 1);
    end
    for (int i = 0; i < stall; i++) begin
      check_eq("stall_rdy", ready_o, 0);
      valid_i = 1'b1; op_a_i = $urandom; op_b_i = $urandom;
      @(negedge clk);
      check_eq("stall_vld", valid_o, 1);
      check_eq("stall_res", result_o, exp);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1 check_eq("b2b_rdy", ready_o, 1);
    last_res = exp;
    if (drain) begin
      @(negedge clk);
      check_eq("drained", valid_o, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    operator_i = DIV; op_a_i = 0; op_b_i = 0; data_ind_timing_i = 1'b0;
    last_res = RST_RES;
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", ready_o, 0);
    check_eq("rst_vld", valid_o, 0);
    check_eq("rst_res", result_o, RST_RES);
    check_eq("rst_en", div_en_o, 0);
    check_eq("rst_dvld", div_valid_o, 0);
    rst_n = 1'b1;
    #1 check_eq("idle_rdy", ready_o, 1);
    @(negedge clk);

    txn(DIVU, 32'd100, 32'd7, 1'b0, 0, 1'b0);
    txn(REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 3, 1'b1);
    txn(DIV, 32'd1234, 32'd0, 1'b0, 0, 1'b0);
    txn(DIV, 32'd1234, 32'd0, 1'b1, 0, 1'b0);
    txn(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    txn(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    txn(REMU, 32'd55, 32'd0, 1'b0, 0, 1'b1);

    // Kill in the middle of a divider operation, with a competing request
    lat_min = 6; lat_max = 6;
    valid_i = 1'b1; operator_i = DIVU; op_a_i = 32'd1000; op_b_i = 32'd3; data_ind_timing_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("kill_pre", div_valid_o, 1);
    kill_i = 1'b1; valid_i = 1'b1; operator_i = DIVU; op_a_i = 32'd5; op_b_i = 32'd1;
    #1 check_eq("kill_dvld", div_valid_o, 0);
    @(negedge clk);
    kill_i = 1'b0; valid_i = 1'b0;
    check_eq("kill_vld", valid_o, 0);
    check_eq("kill_idle", ready_o, 1);
    check_eq("kill_en", div_en_o, 0);
    repeat (12) @(negedge clk);
    check_eq("kill_quiet", valid_o, 0);
    check_eq("kill_res", result_o, last_res);
    lat_min = 2; lat_max = 5;
    txn(DIVU, 32'd9, 32'd3, 1'b0, 0, 1'b1);

    // Reset while the divider is running
    valid_i = 1'b1; operator_i = DIV; op_a_i = 32'd77; op_b_i = 32'd5; data_ind_timing_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("mrst_rdy", ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mrst_vld", valid_o, 0);
    check_eq("mrst_dvld", div_valid_o, 0);
    check_eq("mrst_en", div_en_o, 0);
    check_eq("mrst_drdy", div_ready_o, 0);
    check_eq("mrst_res", result_o, RST_RES);
    check_eq("mrst_a", div_op_a_o, 0);
    check_eq("mrst_b", div_op_b_o, 0);
    #1 check_eq("mrst_idle", ready_o, 1);
    @(negedge clk);
    txn(DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 0, 1'b1);

    // Randomized requests biased toward the special cases
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(3, 0));
      case ($urandom_range(5, 0))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = $urandom_range(1000, 0); b = $urandom_range(20, 1); end
        3:       begin a = -$urandom_range(1000, 0); b = $urandom_range(20, 1); end
        4:       begin a = $urandom; b = ($urandom_range(1, 0) != 0) ? 32'd1 : 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      txn(op, a, b, ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0,
          ($urandom_range(1, 0) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
